cordic_cos_ctrl: RTL
====================

Name: cordic_cos_ctrl

Overview:
Multi-cycle, iteration-sequenced CORDIC cosine unit. It reuses one shift-add rotation stage across ITERATIONS clock cycles instead of a fully unrolled combinational chain.
Accepts an IEEE-754 single-precision angle in radians and returns cos(angle) as signed Q2.30. It does this under a start/done handshake with a clock-enable, compatible with a Nios II multi-cycle custom-instruction slot.
Owns the FSM, the iteration counter, the arctangent ROM sequencing and the float-to-fixed conversion.

Parameters:
ITERATIONS, 16, number of rotation iterations (legal 1..30)
KINIT, 32'h26DD3B6B, initial x value: CORDIC gain 1/K ≈ 0.6072529350 in Q2.30 (valid for ITERATIONS ≥ 14)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clk_en  in  1  high: block advances this cycle; low: all registers hold
start  in  1  one-cycle request; sampled only in IDLE with clk_en=1
dataa  in  32  IEEE-754 single angle, radians
result  out  32  cos(angle), signed Q2.30; held until next accepted start
done  out  1  one-cycle pulse; result valid in the same cycle
busy  out  1  high from the cycle after start is accepted until done is asserted
range_err  out  1  sticky per operation: |angle| ≥ 2.0, theta saturated

Behaviour:
- Reset values: result=0, done=0, busy=0, range_err=0, state=IDLE, counter=0.
- FSM states: IDLE, CONVERT, ITERATE, FINISH.
  - IDLE -> CONVERT on start & clk_en. dataa is latched at this point.
  - CONVERT (1 cycle): compute theta (Q2.30); set x=KINIT, y=0, z=theta, i=0.
  - ITERATE (ITERATIONS cycles):
    - d = (z ≥ 0) ? +1 : −1
    - x ← x − d·(y>>>i); y ← y + d·(x>>>i)
    - z ← z − d·atan_rom[i]; i ← i+1
    - Leave when i = ITERATIONS−1 has been applied.
  - FINISH: result ← x, done=1 for exactly one cycle, busy=0 -> IDLE.
- Latency: start accepted at edge T -> done high in cycle T+ITERATIONS+2.
- clk_en=0 freezes state, counter, datapath and outputs. A pending done pulse is extended until the first clk_en=1 cycle.
- start while busy: ignored; no queueing.
- start in the same cycle as done: ignored; the next start is accepted in IDLE one cycle later.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; partial result discarded.
- atan_rom[i] = round(atan(2^-i)·2^30) for i = 0..29; atan_rom[0] = 32'h3243F6A9. Shifts are arithmetic. All datapath registers are 32-bit two's complement; intermediate overflow is impossible for |theta| < 2.
- Float -> Q2.30 conversion (e = exponent field, m = {1, fraction}):
  - dataa[30:0] = 0, or e < 97: theta = 0.
  - e ≥ 128, or e = 255 (Inf/NaN): theta = ±32'h7FFFFFFF by sign bit, range_err = 1.
  - Otherwise: theta = m shifted left by e−120 if e ≥ 120, else right by 120−e, truncated; negated if the sign bit is set.
- Angles above the convergence limit (≈1.7433 rad) are not clamped. The result approximates cos(1.7433), range_err stays 0 if |angle| < 2.
- range_err is cleared when the next start is accepted.

Optional Feature:
CORDIC_SIN_OUT_EN
- Defined: adds output port result_sin [31:0], signed Q2.30. It is loaded from y in FINISH alongside result, resets to 0, and follows the same hold rules.
- Undefined: port absent; y is still computed internally; cos behaviour identical.

Test Plan:
- Reset, then start with dataa=32'h00000000 -> done at cycle T+18 (ITERATIONS=16); result within ±2^15 LSB of 32'h40000000; range_err=0.
- dataa=32'h3F800000 (1.0), then 32'hBF800000 (−1.0) -> both results within ±2^15 LSB of 32'h2294501F.
- dataa=32'h3F000000 (0.5) -> result within ±2^15 LSB of 32'h382A500E. Toggle clk_en low for 3 cycles mid-ITERATE -> done delayed by exactly 3 cycles, same result.
- dataa=32'h40200000 (2.5) -> range_err=1, theta saturated, done still pulses. Next start with 0.5 -> range_err clears.
- Reset asserted 5 cycles into ITERATE -> next cycle done=0, busy=0, result=0. A fresh start with 1.0 completes correctly.
- start re-asserted every cycle while busy -> exactly one done per accepted operation. dataa changed while busy has no effect on result.

Source files
------------

// File: rtl/cordic_cos_ctrl.sv
// cordic_cos_ctrl -- iteration-sequenced CORDIC cosine unit.
//
// Takes an IEEE-754 single-precision angle in radians and returns cos(angle)
// as signed Q2.30. A single shift-add rotation stage is reused for ITERATIONS
// cycles. The block is sized to fit a multi-cycle custom-instruction slot.
//
// Handshake: start is a one-cycle request. It is accepted only when the FSM
// is IDLE, clk_en=1 and no done pulse is currently showing. The angle on
// dataa is latched on that same edge. busy rises on the following cycle.
// done pulses for one clk_en=1 cycle with result valid alongside it, and busy
// drops at that point. Requests while busy, or in the done cycle itself, are
// dropped rather than queued. clk_en=0 freezes every register, so a pending
// done pulse stretches until the next enabled cycle.
//
// Optional build macro: CORDIC_SIN_OUT_EN adds result_sin (the y register).
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   clk_en     advance enable; low holds all state
//   start      operation request
//   dataa      IEEE-754 single angle in radians
//   result     cos(angle), signed Q2.30, held until the next accepted start
//   result_sin sin(angle), signed Q2.30 (only with CORDIC_SIN_OUT_EN)
//   done       one-cycle completion pulse
//   busy       operation in flight
//   range_err  |angle| >= 2.0 for the current operation (theta saturated)
//   fsm_state  current FSM state, for observation
module cordic_cos_ctrl #(
  parameter int unsigned ITERATIONS = 16,
  parameter logic [31:0] KINIT      = 32'h26DD3B6B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
`ifdef CORDIC_SIN_OUT_EN
  output logic [31:0] result_sin,
`endif
  output logic        done,
  output logic        busy,
  output logic        range_err,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {IDLE, CONVERT, ITERATE, FINISH} state_t;

  localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

  state_t             state;
  logic [4:0]         iter;
  logic [31:0]        angle;
  logic signed [31:0] x, y, z;

  // Float -> Q2.30 conversion of the latched angle.
  logic [7:0]         exp_field;
  logic [31:0]        mag;
  logic [31:0]        theta;
  logic               theta_sat;

  // Per-iteration shifted terms and arctangent constant.
  logic signed [31:0] x_sh, y_sh, atan_i;

  assign fsm_state = state;

  // round(atan(2^-i) * 2^30); entries 30 and 31 are never addressed.
  function automatic logic [31:0] atan_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_rom = 32'h3243F6A9;
      5'd1:    atan_rom = 32'h1DAC6705;
      5'd2:    atan_rom = 32'h0FADBAFD;
      5'd3:    atan_rom = 32'h07F56EA7;
      5'd4:    atan_rom = 32'h03FEAB77;
      5'd5:    atan_rom = 32'h01FFD55C;
      5'd6:    atan_rom = 32'h00FFFAAB;
      5'd7:    atan_rom = 32'h007FFF55;
      5'd8:    atan_rom = 32'h003FFFEB;
      5'd9:    atan_rom = 32'h001FFFFD;
      5'd10:   atan_rom = 32'h00100000;
      5'd11:   atan_rom = 32'h00080000;
      5'd12:   atan_rom = 32'h00040000;
      5'd13:   atan_rom = 32'h00020000;
      5'd14:   atan_rom = 32'h00010000;
      5'd15:   atan_rom = 32'h00008000;
      5'd16:   atan_rom = 32'h00004000;
      5'd17:   atan_rom = 32'h00002000;
      5'd18:   atan_rom = 32'h00001000;
      5'd19:   atan_rom = 32'h00000800;
      5'd20:   atan_rom = 32'h00000400;
      5'd21:   atan_rom = 32'h00000200;
      5'd22:   atan_rom = 32'h00000100;
      5'd23:   atan_rom = 32'h00000080;
      5'd24:   atan_rom = 32'h00000040;
      5'd25:   atan_rom = 32'h00000020;
      5'd26:   atan_rom = 32'h00000010;
      5'd27:   atan_rom = 32'h00000008;
      5'd28:   atan_rom = 32'h00000004;
      5'd29:   atan_rom = 32'h00000002;
      default: atan_rom = 32'h00000000;
    endcase
  endfunction

  // The mantissa {1,frac} has 23 fraction bits and Q2.30 has 30, so an
  // exponent of 127 (1.x) needs a left shift of 7. That is where the bias of
  // 120 comes from. Exponent 128 and above means |angle| >= 2, which cannot be
  // represented in Q2.30, so the magnitude saturates instead.
  always_comb begin
    exp_field = angle[30:23];
    mag       = 32'd0;
    theta_sat = 1'b0;
    if (angle[30:0] == 31'd0 || exp_field < 8'd97) begin
      mag = 32'd0;
    end else if (exp_field >= 8'd128) begin
      mag       = 32'h7FFFFFFF;
      theta_sat = 1'b1;
    end else if (exp_field >= 8'd120) begin
      mag = {8'd0, 1'b1, angle[22:0]} << (exp_field - 8'd120);
    end else begin
      mag = {8'd0, 1'b1, angle[22:0]} >> (8'd120 - exp_field);
    end
    theta = angle[31] ? (32'd0 - mag) : mag;
  end

  assign x_sh   = x >>> iter;
  assign y_sh   = y >>> iter;
  assign atan_i = $signed(atan_rom(iter));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      iter      <= 5'd0;
      angle     <= 32'd0;
      x         <= 32'sd0;
      y         <= 32'sd0;
      z         <= 32'sd0;
      result    <= 32'd0;
`ifdef CORDIC_SIN_OUT_EN
      result_sin <= 32'd0;
`endif
      done      <= 1'b0;
      busy      <= 1'b0;
      range_err <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // done is still high in the first IDLE cycle; a start seen then
          // is dropped so each request maps to exactly one done.
          if (start && !done) begin
            angle     <= dataa;
            busy      <= 1'b1;
            range_err <= 1'b0;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          x         <= $signed(KINIT);
          y         <= 32'sd0;
          z         <= $signed(theta);
          iter      <= 5'd0;
          range_err <= theta_sat;
          state     <= ITERATE;
        end
        ITERATE: begin
          // Rotate toward z = 0: positive residual angle means d = +1.
          if (!z[31]) begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - atan_i;
          end else begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + atan_i;
          end
          iter <= iter + 5'd1;
          if (iter == LAST_ITER) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          result <= x;
`ifdef CORDIC_SIN_OUT_EN
          result_sin <= y;
`endif
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
